// File: rtl/anc_pkg.sv
// anc_pkg: shared constants and FSM state encoding for the ANC speaker driver.
//   SAMPLE_W   - audio sample width (signed)
//   GAIN_W     - gain register width (holds 0..GAIN_MAX)
//   GAIN_MAX   - full-scale gain (unity = GAIN_MAX / 2^GAIN_SHIFT)
//   GAIN_SHIFT - fixed-point shift applied after the gain multiply
package anc_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 6;
  localparam int GAIN_MAX   = 32;
  localparam int GAIN_SHIFT = 5;

  typedef enum logic [2:0] {IDLE, WRITE, READ, SCALE, UPDATE, DONE} anc_state_e;
endpackage

// File: rtl/sample_delay_line.sv
// sample_delay_line: circular sample buffer modelling the acoustic path delay.
//   clk_in, rst_n_in - clock, async active-low reset (pointer/fill only)
//   wr_en_in         - store wr_data_in at wr_ptr, advance wr_ptr
//   rd_en_in         - register sample written rd_delay_in writes ago
//   rd_data_out      - registered read data, 0 while history is too short
module sample_delay_line
  import anc_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       wr_en_in,
  input  logic signed [SAMPLE_W-1:0] wr_data_in,
  input  logic                       rd_en_in,
  input  logic [$clog2(DEPTH)-1:0]   rd_delay_in,
  output logic signed [SAMPLE_W-1:0] rd_data_out
);
  localparam int AW = $clog2(DEPTH);

  logic signed [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW:0]                r_fill;
  logic [AW-1:0]              w_rd_addr;
  logic                       w_valid;

  // Newest sample sits at wr_ptr-1; power-of-two depth makes the wrap free.
  assign w_rd_addr = r_wr_ptr - AW'(1) - rd_delay_in;
  // Stale buffer contents are never cleared, so mask reads past the history.
  assign w_valid   = r_fill > {1'b0, rd_delay_in};

  always_ff @(posedge clk_in) begin
    if (wr_en_in) r_mem[r_wr_ptr] <= wr_data_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      rd_data_out <= '0;
    end else begin
      if (wr_en_in) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_fill != (AW+1)'(DEPTH)) r_fill <= r_fill + 1'b1;
      end
      if (rd_en_in) rd_data_out <= w_valid ? r_mem[w_rd_addr] : '0;
    end
  end
endmodule

// File: rtl/anc_speaker_driver.sv
// anc_speaker_driver: feed-forward ANC path with sign-sign gain adaptation.
//   clk_in, rst_n_in   - clock, async active-low reset
//   ready_in           - strobe: sample pair valid (taken only in IDLE)
//   ambient_sample_in  - reference mic sample
//   feedback_sample_in - in-cup error mic sample
//   delay_in           - acoustic delay in samples
//   speaker_output_out - anti-noise sample, updated in SCALE
//   gain_out           - cancellation gain 0..32 (out of 32)
//   done_out           - one-cycle strobe in DONE
// Build option: ANC_ADAPT_EN enables the UPDATE state and gain adaptation;
// without it the gain is fixed at GAIN_INIT and latency drops to 4 cycles.
module anc_speaker_driver
  import anc_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int GAIN_INIT = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       ready_in,
  input  logic signed [SAMPLE_W-1:0] ambient_sample_in,
  input  logic signed [SAMPLE_W-1:0] feedback_sample_in,
  input  logic [$clog2(DEPTH)-1:0]   delay_in,
  output logic signed [SAMPLE_W-1:0] speaker_output_out,
  output logic [GAIN_W-1:0]          gain_out,
  output logic                       done_out
);
  localparam int AW = $clog2(DEPTH);

  anc_state_e                 r_state, w_next;
  logic signed [SAMPLE_W-1:0] r_amb;
  logic [AW-1:0]              r_delay;
  logic signed [SAMPLE_W-1:0] w_delayed;
  logic [GAIN_W-1:0]          w_gain;
  logic                       w_wr_en, w_rd_en, w_take;
  logic signed [21:0]         w_prod, w_shr;
  logic signed [SAMPLE_W-1:0] w_sat;

  assign w_take = (r_state == IDLE) && ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_wr_en  = 1'b0;
    w_rd_en  = 1'b0;
    done_out = 1'b0;
    case (r_state)
      IDLE:   if (ready_in) w_next = WRITE;
      WRITE:  begin w_wr_en = 1'b1; w_next = READ; end
      READ:   begin w_rd_en = 1'b1; w_next = SCALE; end
`ifdef ANC_ADAPT_EN
      SCALE:  w_next = UPDATE;
      UPDATE: w_next = DONE;
`else
      SCALE:  w_next = DONE;
`endif
      DONE:   begin done_out = 1'b1; w_next = IDLE; end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_amb   <= '0;
      r_delay <= '0;
    end else if (w_take) begin
      r_amb   <= ambient_sample_in;
      r_delay <= delay_in;
    end
  end

  sample_delay_line #(.DEPTH(DEPTH)) u_dly (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .wr_en_in    (w_wr_en),
    .wr_data_in  (r_amb),
    .rd_en_in    (w_rd_en),
    .rd_delay_in (r_delay),
    .rd_data_out (w_delayed)
  );

  // 22 bits covers -32768*32 and its negation without overflow.
  assign w_prod = -(22'(w_delayed) * $signed({16'd0, w_gain}));
  assign w_shr  = w_prod >>> GAIN_SHIFT;

  always_comb begin
    w_sat = w_shr[SAMPLE_W-1:0];
    if (w_shr > 22'sd32767)       w_sat = 16'sh7fff;
    else if (w_shr < -22'sd32768) w_sat = 16'sh8000;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)             speaker_output_out <= '0;
    else if (r_state == SCALE) speaker_output_out <= w_sat;
  end

`ifdef ANC_ADAPT_EN
  logic signed [SAMPLE_W-1:0] r_fb;
  logic [GAIN_W-1:0]          r_gain;

  // Sign-sign LMS: same sign means residual still tracks the reference,
  // so push harder; opposite sign means over-cancelling, back off.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_fb   <= '0;
      r_gain <= GAIN_W'(GAIN_INIT);
    end else begin
      if (w_take) r_fb <= feedback_sample_in;
      if (r_state == UPDATE && r_fb != '0 && w_delayed != '0) begin
        if (r_fb[SAMPLE_W-1] == w_delayed[SAMPLE_W-1]) begin
          if (r_gain < GAIN_W'(GAIN_MAX)) r_gain <= r_gain + 1'b1;
        end else if (r_gain != '0) begin
          r_gain <= r_gain - 1'b1;
        end
      end
    end
  end
  assign w_gain = r_gain;
`else
  logic w_unused_fb;
  assign w_unused_fb = ^feedback_sample_in;
  assign w_gain      = GAIN_W'(GAIN_INIT);
`endif

  assign gain_out = w_gain;
endmodule

// File: tb/tb_anc_speaker_driver.sv
module tb_anc_speaker_driver;
  localparam int DEPTH = 256;
  localparam int GI    = 16;
  localparam int LIMIT = 12;
`ifdef ANC_ADAPT_EN
  localparam int LAT   = 5;
  localparam bit ADAPT = 1'b1;
`else
  localparam int LAT   = 4;
  localparam bit ADAPT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               ready = 1'b0;
  logic signed [15:0] amb = '0, fb = '0;
  logic [7:0]         dly = '0;
  logic signed [15:0] spk;
  logic [5:0]         gain;
  logic               done;

  always #5 clk = ~clk;

  anc_speaker_driver #(.DEPTH(DEPTH), .GAIN_INIT(GI)) dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .ready_in           (ready),
    .ambient_sample_in  (amb),
    .feedback_sample_in (fb),
    .delay_in           (dly),
    .speaker_output_out (spk),
    .gain_out           (gain),
    .done_out           (done)
  );

  int total = 0, bad = 0;

  // Reference model: full history of accepted ambient samples since reset.
  int hist[$];
  int m_gain, m_spk;

  typedef struct {bit rst; int amb; int fb; int dly; int e_spk; int e_gain;} vec_t;
  vec_t vt[6];

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int scale(input int d, input int g);
    int p;
    p = -(d * g);
    p = p >>> 5;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_gain = GI;
    m_spk  = 0;
  endfunction

  task automatic do_reset();
    ready = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  // Issue one sample; optionally hammer ready_in with junk while busy.
  task automatic send(input int a, input int f, input int d, input bit noise);
    int k, dl;
    bit seen;
    logic signed [15:0] j;
    @(negedge clk);
    amb = 16'(a); fb = 16'(f); dly = 8'(d); ready = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < LIMIT) begin
      @(negedge clk);
      k++;
      if (noise && k < LAT - 1) begin
        ready = 1'b1;
        j = 16'($urandom); amb = j;
        j = 16'($urandom); fb = j;
        dly = 8'($urandom);
      end else begin
        ready = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
    chk("latency", k, LAT);
    hist.push_back(a);
    dl = (hist.size() > d) ? hist[hist.size() - 1 - d] : 0;
    m_spk = scale(dl, m_gain);
    if (ADAPT && f != 0 && dl != 0) begin
      if ((f < 0) == (dl < 0)) m_gain = (m_gain < 32) ? m_gain + 1 : 32;
      else                     m_gain = (m_gain > 0) ? m_gain - 1 : 0;
    end
    chk("speaker", int'(spk), m_spk);
    chk("gain", int'(gain), m_gain);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    logic signed [15:0] ra, rf;
    int nd;

    vt[0] = '{1'b1, 1000, 0, 0, -500, 16};
    vt[1] = '{1'b1,  100, 0, 3,    0, 16};
    vt[2] = '{1'b0,  200, 0, 3,    0, 16};
    vt[3] = '{1'b0,  300, 0, 3,    0, 16};
    vt[4] = '{1'b0,  400, 0, 3,  -50, 16};
    vt[5] = '{1'b0,  500, 0, 3, -100, 16};

    // Power-on reset and reset-state checks.
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_speaker", int'(spk), 0);
    chk("rst_gain", int'(gain), GI);
    chk("rst_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();

    // Directed vectors: single sample and delay-masked fill.
    for (int i = 0; i < 6; i++) begin
      if (vt[i].rst) do_reset();
      send(vt[i].amb, vt[i].fb, vt[i].dly, 1'b0);
      chk("vec_speaker", int'(spk), vt[i].e_spk);
      chk("vec_gain", int'(gain), vt[i].e_gain);
    end

    // Gain driven up, most negative sample -> positive saturation.
    do_reset();
    for (int i = 0; i < 40; i++) send(-32768, -1000, 0, 1'b0);

    // Opposite signs -> gain drains and floors.
    do_reset();
    for (int i = 0; i < 20; i++) send(1000, -50, 0, 1'b0);

    // Long run across the pointer wrap with maximum delay and busy noise.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rf = ($urandom_range(0, 4) == 0) ? 16'sd0 : 16'($urandom);
      send(ra, rf, 255, (i % 3) == 0);
    end

    // Random delays.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'sd0 : 16'($urandom);
      rf = ($urandom_range(0, 4) == 0) ? 16'sd0 : 16'($urandom);
      send(ra, rf, $urandom_range(0, 15), $urandom_range(0, 1) == 1);
    end

    // Reset during SCALE aborts the sample without a done pulse.
    do_reset();
    send(1000, 0, 0, 1'b0);
    @(negedge clk);
    amb = 16'sd2000; fb = 16'sd0; dly = 8'd0; ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("abort_speaker", int'(spk), 0);
    chk("abort_gain", int'(gain), GI);
    chk("abort_done", int'(done), 0);
    nd = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6) begin @(negedge clk); nd += int'(done); end
    chk("abort_no_done", nd, 0);
    send(300, 0, 0, 1'b0);
    send(-700, 0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/anc_speaker_driver.md
ANC_SPEAKER_DRIVER -- requirements
Module: anc_speaker_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 256, delay-line depth in samples (power of two).
REQ-002 SHALL have parameter GAIN_INIT, default 16, reset gain out of 32.
REQ-003 SHALL have port clk_in  input  1  system clock.
REQ-004 SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ready_in  input  1  one-cycle strobe: new sample pair valid.
REQ-006 SHALL have port ambient_sample_in  input  16 signed  reference (outer) microphone sample.
REQ-007 SHALL have port feedback_sample_in  input  16 signed  in-cup error microphone sample.
REQ-008 SHALL have port delay_in  input  $clog2(DEPTH)  modelled acoustic delay in samples.
REQ-009 SHALL have port speaker_output_out  output  16 signed  anti-noise sample to the speaker.
REQ-010 SHALL have port gain_out  output  6  current cancellation gain, 0..32 (out of 32).
REQ-011 SHALL have port done_out  output  1  one-cycle strobe: speaker_output_out updated.

Function
REQ-012 SHALL use FSM states IDLE, WRITE, READ, SCALE, UPDATE, DONE; IDLE->WRITE only on ready_in; every other state advances unconditionally; DONE->IDLE.
REQ-013 SHALL capture ambient_sample_in, feedback_sample_in and delay_in in the cycle ready_in is sampled in IDLE.
REQ-014 SHALL ignore ready_in in any state other than IDLE (no queuing).
REQ-015 WRITE SHALL store the ambient sample at wr_ptr, then increment wr_ptr modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-016 READ SHALL fetch delayed = buffer[(newest_index - delay) mod DEPTH]; delay 0 returns the sample just written.
REQ-017 SHALL return delayed = 0 while the count of samples written since reset is <= delay (fill counter saturates at DEPTH).
REQ-018 SCALE SHALL compute -(delayed * gain) >>> 5 at 22-bit signed precision, saturated to [-32768, 32767].
REQ-019 UPDATE SHALL apply sign-sign adaptation: if feedback and delayed are nonzero with equal signs, gain+1 (clamped at 32); opposite signs, gain-1 (clamped at 0); either zero, hold.
REQ-020 speaker_output_out SHALL update in SCALE and hold until the next SCALE; gain_out SHALL reflect the updated gain from the cycle after UPDATE.
REQ-021 done_out SHALL pulse high for exactly one cycle in DONE; latency from ready_in to done_out is 5 cycles.

Reset
REQ-022 Assertion of rst_n_in SHALL immediately return the FSM to IDLE, even mid-operation, with no done_out for the aborted sample.
REQ-023 Reset SHALL clear speaker_output_out to 0, done_out to 0, wr_ptr to 0, fill counter to 0, and load gain to GAIN_INIT; buffer contents are not cleared (masked by REQ-017).

Configuration
REQ-024 With ANC_ADAPT_EN defined, UPDATE SHALL exist and behave per REQ-019.
REQ-025 Without ANC_ADAPT_EN, gain SHALL be held constant at GAIN_INIT, SCALE SHALL go directly to DONE, and latency SHALL be 4 cycles.

Structure
REQ-026 Package anc_pkg SHALL hold SAMPLE_W=16, GAIN_W=6, GAIN_MAX=32, GAIN_SHIFT=5 and the FSM state enum.
REQ-027 The circular buffer SHALL be a sub-module sample_delay_line (one write port, one synchronous read port, wr_ptr and fill counter inside).

Verification
REQ-028 After reset, gain_out=16, speaker_output_out=0; ready_in with ambient=1000, delay=0 -> done_out 5 cycles later, speaker_output_out=-500.
REQ-029 delay=3, ambient 100,200,300,400,500 -> outputs 0,0,0,-50,-100 (gain frozen by feedback=0).
REQ-030 ambient=-32768, gain forced to 32 via repeated same-sign feedback -> speaker_output_out saturates to 32767, gain_out stays 32.
REQ-031 Constant ambient=1000, feedback=-50 for 20 samples -> gain_out decrements to 0 and holds at 0.
REQ-032 300 samples, delay=255 -> correct wrap-around of wr_ptr; extra ready_in pulses during busy states produce no extra done_out.
REQ-033 rst_n_in asserted during SCALE -> no done_out, outputs at reset values; next ready_in completes normally.
